// File: rtl/eeg_dct_pkg.sv
// Shared types and constants for the EEG-to-DCT framing path.
// One frame is eight signed 8-bit samples; the DCT core produces 19-bit coefficients.
package eeg_dct_pkg;

    localparam int unsigned FRAME_LEN = 8;
    localparam int unsigned SAMPLE_W  = 8;
    localparam int unsigned COEF_W    = 19;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    // Element 0 is the oldest sample of the frame.
    typedef sample_t [FRAME_LEN-1:0] frame_t;

endpackage

// File: rtl/eeg_dct_pingpong_bank.sv
// Ping-pong sample store: one bank collects samples while the other presents a frame.
// A full write bank waits as "pending" until the presented frame is consumed.
module eeg_dct_pingpong_bank
    import eeg_dct_pkg::*;
#(
    parameter int unsigned FRAME_LEN = eeg_dct_pkg::FRAME_LEN
) (
    input  logic    i_clk,
    input  logic    i_rst,
    input  logic    i_wr_en,
    input  sample_t i_wr_data,
    input  logic    i_flush,
    input  logic    i_consume,
    output frame_t  o_frame,
    output logic    o_valid,
    output logic    o_full
);

    localparam int unsigned      IDX_W    = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    frame_t           r_wr_bank;
    frame_t           r_rd_bank;
    frame_t           w_fill;
    logic [IDX_W-1:0] r_wr_idx;
    logic             r_full;
    logic             r_valid;
    logic             w_complete;
    logic             w_swap;

    // Flush wins over a completing write, so a flushed 8th sample never swaps in.
    assign w_complete = i_wr_en & ~i_flush & (r_wr_idx == LAST_IDX);
    assign w_swap     = ~i_flush & (r_full | w_complete) & (~r_valid | i_consume);

    // Write bank as it will look including this cycle's sample, so a swap
    // on the completing write carries the 8th sample straight across.
    always_comb begin
        w_fill = r_wr_bank;
        if (i_wr_en) begin
            w_fill[r_wr_idx] = i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_bank <= '0;
            r_rd_bank <= '0;
            r_wr_idx  <= '0;
            r_full    <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            if (i_wr_en && !i_flush) begin
                r_wr_bank[r_wr_idx] <= i_wr_data;
            end

            if (w_swap) begin
                r_rd_bank <= w_fill;
                r_valid   <= 1'b1;
            end else if (i_consume) begin
                r_valid <= 1'b0;
            end

            if (i_flush || w_swap) begin
                r_wr_idx <= '0;
                r_full   <= 1'b0;
            end else if (w_complete) begin
                r_wr_idx <= '0;
                r_full   <= 1'b1;
            end else if (i_wr_en) begin
                r_wr_idx <= r_wr_idx + 1'b1;
            end
        end
    end

    assign o_frame = r_rd_bank;
    assign o_valid = r_valid;
    assign o_full  = r_full;

endmodule

// File: rtl/eeg_dct_framer.sv
// Frames a serial EEG sample stream into 8-sample blocks for the 8-point DCT core,
// driving its capture/select strobes and tracking coefficient latency.
module eeg_dct_framer
    import eeg_dct_pkg::*;
#(
    parameter int unsigned FRAME_LEN = eeg_dct_pkg::FRAME_LEN,
    parameter int unsigned DCT_LAT   = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             blk_enable,
    input  logic             flush,
    input  sample_t          sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    input  logic             frame_ready,
    output logic             frame_valid,
    output sample_t          samp0,
    output sample_t          samp1,
    output sample_t          samp2,
    output sample_t          samp3,
    output sample_t          samp4,
    output sample_t          samp5,
    output sample_t          samp6,
    output sample_t          samp7,
    output logic             dct_en,
    output logic             dct_cs,
    output logic             coef_valid,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             overflow
);

    logic               r_live;
    logic               r_dct_cs;
    logic               r_overflow;
    logic [DCT_LAT-1:0] r_coef_pipe;
    logic [CNT_W-1:0]   r_frame_cnt;

    logic   w_sample_ready;
    logic   w_accept;
    logic   w_dct_en;
    logic   w_bank_full;
    logic   w_frame_valid;
    frame_t w_frame;

    // r_live holds sample_ready low for the first cycle after reset release.
    assign w_sample_ready = r_live & blk_enable & ~(w_bank_full & w_frame_valid);
    assign w_accept       = sample_valid & w_sample_ready;
    assign w_dct_en       = w_frame_valid & frame_ready;

    eeg_dct_pingpong_bank #(
        .FRAME_LEN (FRAME_LEN)
    ) u_bank (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_wr_en   (w_accept),
        .i_wr_data (sample_in),
        .i_flush   (flush),
        .i_consume (w_dct_en),
        .o_frame   (w_frame),
        .o_valid   (w_frame_valid),
        .o_full    (w_bank_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live      <= 1'b0;
            r_dct_cs    <= 1'b0;
            r_overflow  <= 1'b0;
            r_coef_pipe <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_live     <= 1'b1;
            r_dct_cs   <= blk_enable;
            r_overflow <= r_overflow | (sample_valid & blk_enable & ~w_sample_ready);
            if (w_dct_en) begin
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
            r_coef_pipe[0] <= w_dct_en;
            for (int unsigned i = 1; i < DCT_LAT; i++) begin
                r_coef_pipe[i] <= r_coef_pipe[i-1];
            end
        end
    end

    assign sample_ready = w_sample_ready;
    assign frame_valid  = w_frame_valid;
    assign dct_en       = w_dct_en;
    assign dct_cs       = r_dct_cs;
    assign coef_valid   = r_coef_pipe[DCT_LAT-1];
    assign frame_cnt    = r_frame_cnt;
    assign overflow     = r_overflow;

    assign samp0 = w_frame[0];
    assign samp1 = w_frame[1];
    assign samp2 = w_frame[2];
    assign samp3 = w_frame[3];
    assign samp4 = w_frame[4];
    assign samp5 = w_frame[5];
    assign samp6 = w_frame[6];
    assign samp7 = w_frame[7];

endmodule

// File: tb/tb_eeg_dct_framer.sv
// Bench for eeg_dct_framer: a frame-queue reference model checks every cycle,
// plus a vector table for the single-frame case and directed corner sequences.
module tb_eeg_dct_framer;

    localparam int unsigned DCT_LAT = 1;
    localparam int unsigned CNT_W   = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic blk_enable = 1'b0;
    logic flush = 1'b0;
    logic sample_valid = 1'b0;
    logic frame_ready = 1'b0;
    logic [7:0] sample_in = '0;

    logic sample_ready, frame_valid, dct_en, dct_cs, coef_valid, overflow;
    logic [7:0] samp0, samp1, samp2, samp3, samp4, samp5, samp6, samp7;
    logic [CNT_W-1:0] frame_cnt;
    logic [63:0] samp_bus;

    assign samp_bus = {samp7, samp6, samp5, samp4, samp3, samp2, samp1, samp0};

    always #5 clk = ~clk;

    eeg_dct_framer #(
        .FRAME_LEN (8),
        .DCT_LAT   (DCT_LAT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .blk_enable   (blk_enable),
        .flush        (flush),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .frame_ready  (frame_ready),
        .frame_valid  (frame_valid),
        .samp0        (samp0),
        .samp1        (samp1),
        .samp2        (samp2),
        .samp3        (samp3),
        .samp4        (samp4),
        .samp5        (samp5),
        .samp6        (samp6),
        .samp7        (samp7),
        .dct_en       (dct_en),
        .dct_cs       (dct_cs),
        .coef_valid   (coef_valid),
        .frame_cnt    (frame_cnt),
        .overflow     (overflow)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: samples being gathered, and a queue of complete frames
    // whose head is the presented frame and whose second entry is a full bank waiting.
    logic [7:0]       m_fill[$];
    logic [63:0]      m_frames[$];
    logic [63:0]      m_shown;
    bit               m_pipe[$];
    logic [CNT_W-1:0] m_cnt;
    bit               m_live, m_cs, m_ovf;
    bit               e_rdy, e_den;

    typedef struct {
        logic       sv;
        logic [7:0] d;
        logic       fr;
        logic       e_rdy;
        logic       e_fv;
        logic       e_den;
        logic       e_cv;
        int         e_cnt;
        logic       chk_samp;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset;
        m_fill.delete();
        m_frames.delete();
        m_pipe.delete();
        for (int i = 0; i < int'(DCT_LAT); i++) m_pipe.push_back(1'b0);
        m_shown = '0;
        m_cnt   = '0;
        m_live  = 1'b0;
        m_cs    = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".samp"},         samp_bus,     64'h0);
        chk({tag, ".frame_valid"},  frame_valid,  64'h0);
        chk({tag, ".sample_ready"}, sample_ready, 64'h0);
        chk({tag, ".dct_en"},       dct_en,       64'h0);
        chk({tag, ".dct_cs"},       dct_cs,       64'h0);
        chk({tag, ".coef_valid"},   coef_valid,   64'h0);
        chk({tag, ".frame_cnt"},    frame_cnt,    64'h0);
        chk({tag, ".overflow"},     overflow,     64'h0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        chk_zero(tag);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic apply(input logic sv, input logic [7:0] d, input logic fr,
                         input logic fl, input logic en);
        sample_valid = sv;
        sample_in    = d;
        frame_ready  = fr;
        flush        = fl;
        blk_enable   = en;
        #1;
    endtask

    // Compare all outputs against the model, advance the model over the edge.
    task automatic finish_cycle;
        logic [63:0] pk;
        e_rdy = m_live && blk_enable && (m_frames.size() < 2);
        e_den = (m_frames.size() > 0) && frame_ready;
        if (m_frames.size() > 0) m_shown = m_frames[0];
        chk("m.sample_ready", sample_ready, e_rdy);
        chk("m.frame_valid",  frame_valid,  m_frames.size() > 0);
        chk("m.dct_en",       dct_en,       e_den);
        chk("m.samp",         samp_bus,     m_shown);
        chk("m.coef_valid",   coef_valid,   m_pipe[0]);
        chk("m.frame_cnt",    frame_cnt,    m_cnt);
        chk("m.dct_cs",       dct_cs,       m_cs);
        chk("m.overflow",     overflow,     m_ovf);

        if (sample_valid && blk_enable && !e_rdy) m_ovf = 1'b1;
        if (flush) begin
            m_fill.delete();
            if (m_frames.size() == 2) void'(m_frames.pop_back());
        end
        if (e_den) begin
            void'(m_frames.pop_front());
            m_cnt++;
        end
        if (sample_valid && e_rdy && !flush) begin
            m_fill.push_back(sample_in);
            if (m_fill.size() == 8) begin
                pk = '0;
                for (int i = 0; i < 8; i++) pk[8*i +: 8] = m_fill[i];
                m_frames.push_back(pk);
                m_fill.delete();
            end
        end
        void'(m_pipe.pop_front());
        m_pipe.push_back(e_den);
        m_cs   = blk_enable;
        m_live = 1'b1;
        @(negedge clk);
    endtask

    task automatic cyc(input logic sv, input logic [7:0] d, input logic fr,
                       input logic fl, input logic en);
        apply(sv, d, fr, fl, en);
        finish_cycle();
    endtask

    initial begin
        logic [7:0] sf[8];
        sf[0] = 8'd1;  sf[1] = 8'd2;  sf[2] = 8'hFD; sf[3] = 8'd4;
        sf[4] = 8'hFB; sf[5] = 8'd6;  sf[6] = 8'd7;  sf[7] = 8'h80;
        for (int i = 0; i < 8; i++)
            tbl[i] = '{sv:1'b1, d:sf[i], fr:1'b1, e_rdy:1'b1, e_fv:1'b0, e_den:1'b0,
                       e_cv:1'b0, e_cnt:0, chk_samp:1'b0};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0};

        #2;
        blk_enable = 1'b1;
        do_reset("reset");

        // Single frame through the vector table.
        apply(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("first_cycle_ready", sample_ready, 64'h0);
        finish_cycle();
        for (int i = 0; i < 11; i++) begin
            apply(tbl[i].sv, tbl[i].d, tbl[i].fr, 1'b0, 1'b1);
            chk($sformatf("t%0d.sample_ready", i), sample_ready, tbl[i].e_rdy);
            chk($sformatf("t%0d.frame_valid", i),  frame_valid,  tbl[i].e_fv);
            chk($sformatf("t%0d.dct_en", i),       dct_en,       tbl[i].e_den);
            chk($sformatf("t%0d.coef_valid", i),   coef_valid,   tbl[i].e_cv);
            chk($sformatf("t%0d.frame_cnt", i),    frame_cnt,    64'(tbl[i].e_cnt));
            if (tbl[i].chk_samp) chk($sformatf("t%0d.samp", i), samp_bus, 64'h800706FB04FD0201);
            finish_cycle();
        end

        // Backpressure, then overflow with both banks full.
        do_reset("reset2");
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b1);
        apply(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
        chk("bp.ready_low", sample_ready, 64'h0);
        chk("bp.first_frame", samp_bus, 64'h0706050403020100);
        finish_cycle();
        apply(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("ovf.set", overflow, 64'h1);
        chk("ovf.samp_kept", samp_bus, 64'h0706050403020100);
        chk("bp.dct_en", dct_en, 64'h1);
        finish_cycle();
        apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("bp.second_frame", samp_bus, 64'h0F0E0D0C0B0A0908);
        chk("bp.cnt1", frame_cnt, 64'h1);
        chk("bp.ready_back", sample_ready, 64'h1);
        finish_cycle();
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("bp.cnt2", frame_cnt, 64'h2);
        chk("ovf.sticky", overflow, 64'h1);
        finish_cycle();

        // Flush discards a partial bank, including a sample offered on the flush cycle.
        do_reset("reset3");
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b1);
        apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("flush.frame", samp_bus, 64'h1716151413121110);
        chk("flush.valid", frame_valid, 64'h1);
        finish_cycle();

        // Completing write coincides with consumption of the presented frame.
        do_reset("reset4");
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) cyc(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b1);
        apply(1'b1, 8'h37, 1'b1, 1'b0, 1'b1);
        chk("swap.dct_en", dct_en, 64'h1);
        finish_cycle();
        apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("swap.valid_held", frame_valid, 64'h1);
        chk("swap.new_frame", samp_bus, 64'h3736353433323130);
        chk("swap.dct_en_once", dct_en, 64'h0);
        finish_cycle();
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // Asynchronous reset between edges, part way into a frame.
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h41 + 8'(i), 1'b0, 1'b0, 1'b1);
        sample_valid = 1'b0;
        frame_ready  = 1'b1;
        #2;
        do_reset("async");
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'd9, 1'b0, 1'b0, 1'b1);
        apply(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("async.frame", samp_bus, 64'h0909090909090909);
        chk("async.dct_en", dct_en, 64'h1);
        finish_cycle();
        apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("async.cnt", frame_cnt, 64'h1);
        finish_cycle();

        // Randomized traffic against the model.
        do_reset("reset5");
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 9) < 7, 8'($urandom),
                (i < 1500) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 4) == 0),
                $urandom_range(0, 49) == 0, $urandom_range(0, 19) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/eeg_dct_framer.md
Name: eeg_dct_framer

Overview:
- Upstream feeder for the 8-point DCT core.
- Accepts a serial stream of signed 8-bit EEG samples and packs them into 8-sample frames.
- Ping-pong buffering lets collection of frame N+1 proceed while frame N waits for the DCT.
- Drives the DCT's eight parallel sample inputs plus its en/cs strobes, and tracks DCT latency to flag when the 19-bit coefficients are valid.

Parameters:
- FRAME_LEN, 8, samples per frame; fixed at 8 to match the DCT core; other values unsupported.
- DCT_LAT, 1, cycles from dct_en high to DCT coefficients valid; legal range 1..8.
- CNT_W, 16, width of the frame counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- blk_enable  in  1  block enable; gates sample acceptance and drives dct_cs.
- flush  in  1  synchronous pulse; discards the partially filled write bank.
- sample_in  in  8  signed EEG sample.
- sample_valid  in  1  sample_in valid.
- sample_ready  out  1  framer can accept a sample this cycle.
- frame_ready  in  1  downstream (DCT side) can take the presented frame.
- frame_valid  out  1  samp0..samp7 hold a complete frame.
- samp0..samp7  out  8 each  signed frame samples; samp0 = oldest.
- dct_en  out  1  DCT capture strobe.
- dct_cs  out  1  DCT chip select.
- coef_valid  out  1  DCT outputs valid this cycle.
- frame_cnt  out  CNT_W  frames issued to the DCT; wraps modulo 2^CNT_W.
- overflow  out  1  sticky flag: a sample was offered while sample_ready=0 and blk_enable=1.

Behaviour:
- Reset (async, rst=1) forces:
  - sample_ready=0, frame_valid=0, dct_en=0, dct_cs=0, coef_valid=0, overflow=0;
  - frame_cnt=0, samp0..7=0;
  - write index=0, both banks empty.
  - sample_ready rises the first cycle after rst deasserts, provided blk_enable=1.
  - Reset mid-frame discards all buffered data; any coef_valid pipeline is cleared.
- Sample acceptance:
  - A sample is accepted when sample_valid & sample_ready.
  - It is written to write-bank slot [write index], and the index increments 0..7.
- sample_ready = blk_enable & !(write bank full & read bank occupied).
- Bank completion: on accepting the 8th sample (index 7), the write bank is full.
  - If the read bank is empty, or is being consumed this same cycle (frame_valid & frame_ready), the banks swap. frame_valid is 1 next cycle with the new data, and the write index returns to 0.
  - Otherwise the write bank holds as full-pending and sample_ready=0 until the read bank is consumed. The swap then occurs on that consume edge.
- Frame transfer:
  - samp0..7 and frame_valid are registered, and samp0..7 are stable while frame_valid=1.
  - dct_en = frame_valid & frame_ready (combinational); it is high for exactly one cycle per frame.
  - frame_valid clears the cycle after transfer unless a swap refills it the same edge.
  - Back-to-back frames sustain one frame per 8 sample cycles with no bubbles.
- dct_cs = blk_enable & !rst, registered.
- coef_valid: a DCT_LAT-deep shift register fed by dct_en. It is a pipeline, so overlapping frames each produce their own pulse.
- frame_cnt increments on every dct_en.
- flush:
  - resets the write index to 0 and empties the write bank, including full-pending;
  - does not affect a presented frame, coef_valid or frame_cnt;
  - a sample accepted in the flush cycle is dropped.
  - flush has priority over a simultaneous bank completion.
- blk_enable=0:
  - sample_ready=0 and dct_cs=0;
  - a presented frame is held, and can still transfer if frame_ready=1;
  - the write index is retained.
- overflow is cleared only by rst.
- Arithmetic: samples pass unmodified as two's-complement; the framer does no scaling.

Decomposition:
- Shared package eeg_dct_pkg holds:
  - FRAME_LEN = 8;
  - SAMPLE_W = 8;
  - COEF_W = 19;
  - the typedef for a signed sample and for an 8-sample frame array.
- One natural sub-module, eeg_dct_pingpong_bank: two 8x8 register banks with a write pointer, a full-pending flag and a swap control.
- The top level holds the handshake, dct_en/dct_cs, the latency pipe, the counter and the flags.

Test Plan:
- Single frame: reset, blk_enable=1, frame_ready=1, feed 8 samples 1,2,-3,4,-5,6,7,-128 on consecutive cycles → next cycle frame_valid=1 with samp0..7 equal to those values, dct_en pulses once, coef_valid one cycle later (DCT_LAT=1), frame_cnt=1.
- Backpressure: frame_ready=0, stream 16 samples 0..15 → first frame holds 0..7, second bank fills 8..15, sample_ready=0 after the 16th. Raise frame_ready → dct_en, then the frame shows 8..15 next cycle. Sample_ready returns after the swap; frame_cnt=1, then 2 after the second transfer.
- Overflow: with both banks full, drive sample_valid=1 → overflow=1 and stays 1 until rst; no stored sample changes.
- Flush: after 5 samples, pulse flush, then feed 8 samples 0x10..0x17 → the frame equals 0x10..0x17; no sample from before the flush appears.
- Simultaneous swap: 8th sample accepted in the same cycle as frame_ready consumes the old frame → frame_valid stays 1 continuously with the new data next cycle; dct_en high exactly one cycle.
- Async reset mid-frame: assert rst between clock edges after 3 samples → all outputs go to 0 immediately. After release, feed 8 samples of value 9 → one frame of all 9 and frame_cnt=1.
